calc_cmd_responder: RTL

//  Responder end of the calculator command interface: the datapath that executes strobed commands.

---
 rtl/calc_cmd_responder_if.sv | 24 ++
 rtl/calc_cmd_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/calc_cmd_responder_if.sv
// Calculator command pin bundle between the commander and the responder datapath.
// Latency: none (wires only).
// Backpressure: none; the commander re-arms the strobe only after busy falls.
interface calc_cmd_responder_if;
    logic       op_strobe;
    logic [3:0] opcode;
    logic [7:0] operand;
    logic [7:0] result;
    logic [2:0] flags;
    logic       busy;
    logic       done;

    // Commander drives the strobe and command fields and observes the responder status.
    modport master (
        output op_strobe, opcode, operand,
        input  result, flags, busy, done
    );

    // Responder samples the command and drives result/status.
    modport slave (
        input  op_strobe, opcode, operand,
        output result, flags, busy, done
    );
endinterface

// File: rtl/calc_cmd_responder.sv
// Executes strobed calculator commands on an 8-bit accumulator, flags {C,Z,X}.
// Latency: strobe first sampled high at T0 -> latch at T(SYNC_STAGES) -> result/done at T(SYNC_STAGES+1).
// Backpressure: none; a rising edge seen while executing is dropped, not queued.
module calc_cmd_responder #(
    parameter int         SYNC_STAGES = 2,      // legal range 2..3
    parameter logic [7:0] ACC_RESET   = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    calc_cmd_responder_if.slave cmd_if
);

    typedef enum logic {ST_IDLE, ST_EXEC} state_t;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_OR  = 4'h2, OP_AND = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4, OP_LSL = 4'h5, OP_LSR = 4'h6, OP_ASR = 4'h7;
    localparam logic [3:0] OP_NEG = 4'h8, OP_INV = 4'h9, OP_REV = 4'hA;
    localparam logic [3:0] OP_LT  = 4'hD, OP_GT  = 4'hE, OP_EQ  = 4'hF;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   fire;

    state_t     state_q;
    logic [3:0] op_q;
    logic [7:0] opnd_q;
    logic [7:0] acc_q;
    logic [2:0] flags_q;
    logic       busy_q;
    logic       done_q;

    logic [7:0] acc_d;
    logic [2:0] flags_d;

    // Synchronize the async strobe; history preset high so a strobe held across reset never fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cmd_if.op_strobe};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign fire = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Accumulator next value and flags for the latched command.
    always_comb begin
        logic [8:0] sum9;
        logic [8:0] diff9;
        logic       c;
        logic       x;
        logic       rsv;
        sum9  = {1'b0, acc_q} + {1'b0, opnd_q};
        diff9 = {1'b0, acc_q} - {1'b0, opnd_q};
        acc_d = acc_q;
        c     = 1'b0;
        x     = 1'b0;
        rsv   = 1'b0;
        case (op_q)
            OP_ADD: begin
                acc_d = sum9[7:0];
                c     = sum9[8];
                x     = (acc_q[7] == opnd_q[7]) && (sum9[7] != acc_q[7]);
            end
            OP_SUB: begin
                acc_d = diff9[7:0];
                c     = diff9[8];
                x     = (acc_q[7] != opnd_q[7]) && (diff9[7] != acc_q[7]);
            end
            OP_OR:  acc_d = acc_q | opnd_q;
            OP_AND: acc_d = acc_q & opnd_q;
            OP_XOR: acc_d = acc_q ^ opnd_q;
            OP_LSL: begin
                acc_d = {acc_q[6:0], 1'b0};
                c     = acc_q[7];
            end
            OP_LSR: begin
                acc_d = {1'b0, acc_q[7:1]};
                c     = acc_q[0];
            end
            OP_ASR: begin
                acc_d = {acc_q[7], acc_q[7:1]};
                c     = acc_q[0];
            end
            OP_NEG: begin
                acc_d = 8'h00 - acc_q;
                c     = (acc_q != 8'h00);
                x     = (acc_q == 8'h80);
            end
            OP_INV: acc_d = ~acc_q;
            OP_REV: begin
                for (int i = 0; i < 8; i++) begin
                    acc_d[i] = acc_q[7-i];
                end
            end
            OP_LT:  x = (acc_q <  opnd_q);
            OP_GT:  x = (acc_q >  opnd_q);
            OP_EQ:  x = (acc_q == opnd_q);
            default: rsv = 1'b1;   // reserved opcodes leave acc alone and clear every flag
        endcase
        flags_d = rsv ? 3'b000 : {c, (acc_d == 8'h00), x};
    end

    // Command FSM: latch on a fresh edge, execute next cycle; reset mid-command discards it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 4'h0;
            opnd_q  <= 8'h00;
            acc_q   <= ACC_RESET;
            flags_q <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (fire) begin
                        op_q    <= cmd_if.opcode;
                        opnd_q  <= cmd_if.operand;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                default: begin
                    acc_q   <= acc_d;
                    flags_q <= flags_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_if.result = acc_q;
    assign cmd_if.flags  = flags_q;
    assign cmd_if.busy   = busy_q;
    assign cmd_if.done   = done_q;

endmodule
